// File: rtl/and_mux_pkg.sv
// Shared constants for the and_mux arbiter slice: FSM state encoding and requester ids.
package and_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } state_t;

  localparam logic ID_AB = 1'b0;
  localparam logic ID_CD = 1'b1;

endpackage

// File: rtl/and_mux.sv
// Shared datapath: e = sel ? (c & d) : (a & b), replicated bitwise over WIDTH.
module and_mux #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  output logic [WIDTH-1:0] e
);

  assign e = sel ? (c & d) : (a & b);

endmodule

// File: rtl/and_mux_rr2.sv
// Two-way arbiter for the and_mux requesters; round-robin by default,
// fixed priority to requester 0 when AND_MUX_ARB_FIXED_PRIO_EN is defined.
module and_mux_rr2
  import and_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  output logic [1:0] gnt_c
);

`ifdef AND_MUX_ARB_FIXED_PRIO_EN
  logic unused_rr;

  assign gnt_c     = {req1 & ~req0, req0};
  assign unused_rr = ^{clk, rst, en};
`else
  logic last;

  // On contention the requester that did not win last time gets the grant.
  assign gnt_c[0] = req0 & (~req1 | last);
  assign gnt_c[1] = req1 & (~req0 | ~last);

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ID_CD;
    end else if (en && (|gnt_c)) begin
      last <= gnt_c[1];
    end
  end
`endif

endmodule

// File: rtl/and_mux_arb.sv
// Arbitrates two requesters onto one external and_mux and returns tagged results.
// Optional build macro: AND_MUX_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
module and_mux_arb
  import and_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic [WIDTH-1:0] mux_c,
  output logic [WIDTH-1:0] mux_d,
  output logic             mux_sel,
  input  logic [WIDTH-1:0] mux_e,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  state_t     state;
  logic [1:0] gnt_c;

  and_mux_rr2 u_rr2 (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .en    (state == ST_IDLE),
    .gnt_c (gnt_c)
  );

  // Grant and operand launch in IDLE, result capture in EVAL; unused pair always zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mux_a     <= '0;
      mux_b     <= '0;
      mux_c     <= '0;
      mux_d     <= '0;
      mux_sel   <= ID_AB;
      res_valid <= 1'b0;
      res_id    <= ID_AB;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|gnt_c) begin
            gnt0  <= gnt_c[0];
            gnt1  <= gnt_c[1];
            busy  <= 1'b1;
            state <= ST_EVAL;
            if (gnt_c[0]) begin
              mux_a   <= x0;
              mux_b   <= y0;
              mux_c   <= '0;
              mux_d   <= '0;
              mux_sel <= ID_AB;
            end else begin
              mux_a   <= '0;
              mux_b   <= '0;
              mux_c   <= x1;
              mux_d   <= y1;
              mux_sel <= ID_CD;
            end
          end
        end
        ST_EVAL: begin
          res_data  <= mux_e;
          res_id    <= mux_sel;
          res_valid <= 1'b1;
          mux_a     <= '0;
          mux_b     <= '0;
          mux_c     <= '0;
          mux_d     <= '0;
          mux_sel   <= ID_AB;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_mux_arb.sv
// Self-checking bench for and_mux_arb driving a real and_mux; results checked via a scoreboard queue.
module tb_and_mux_arb;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 4 + 4 * W;
  localparam logic [W-1:0] Z = '0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic          gnt0, gnt1, mux_sel, res_valid, res_id, busy;
  logic [W-1:0]  mux_a, mux_b, mux_c, mux_d, mux_e, res_data;
  logic [SW-1:0] snap;

  res_t sb[$];
  res_t exp_res;
  int   n_pass = 0;
  int   n_total = 0;
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  and_mux_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0),
    .req1(req1), .x1(x1), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c), .mux_d(mux_d),
    .mux_sel(mux_sel), .mux_e(mux_e),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .busy(busy)
  );

  and_mux #(.WIDTH(W)) u_and_mux (
    .a(mux_a), .b(mux_b), .c(mux_c), .d(mux_d), .sel(mux_sel), .e(mux_e)
  );

  assign snap = {gnt0, gnt1, mux_sel, busy, mux_a, mux_b, mux_c, mux_d};

  // Expected {gnt0,gnt1,mux_sel,busy,a,b,c,d} right after a grant.
  function automatic logic [SW-1:0] exp_grant(input logic id, input logic [W-1:0] xa, input logic [W-1:0] ya);
    if (id == 1'b0) return {1'b1, 1'b0, 1'b0, 1'b1, xa, ya, Z, Z};
    return {1'b0, 1'b1, 1'b1, 1'b1, Z, Z, xa, ya};
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic lst);
`ifdef AND_MUX_ARB_FIXED_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    if (r0 && r1) return ~lst;
    return r0 ? 1'b0 : 1'b1;
`endif
  endfunction

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL result_unexpected got id=%0d data=%h want no result", res_id, res_data);
      end else begin
        exp_res = sb.pop_front();
        if ({res_id, res_data} !== exp_res)
          $display("FAIL result got id=%0d data=%h want id=%0d data=%h",
                   res_id, res_data, exp_res.id, exp_res.data);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got simulation still running want finished");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({snap, res_valid, res_id, res_data} !== '0)
      $display("FAIL reset_outputs got snap=%h rv=%b id=%b data=%h want all 0", snap, res_valid, res_id, res_data);
    else n_pass++;
  endtask

  task automatic test_single(input logic id, input logic [W-1:0] xa, input logic [W-1:0] ya);
    if (id == 1'b0) begin req0 = 1'b1; x0 = xa; y0 = ya; end
    else begin req1 = 1'b1; x1 = xa; y1 = ya; end
    sb.push_back('{id: id, data: xa & ya});
    model_last = id;
    @(negedge clk);
    n_total++;
    if (snap !== exp_grant(id, xa, ya))
      $display("FAIL single_grant id=%0d got %h want %h", id, snap, exp_grant(id, xa, ya));
    else n_pass++;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    n_total++;
    if ({res_valid, snap} !== {1'b1, {SW{1'b0}}})
      $display("FAIL single_eval id=%0d got rv=%b snap=%h want rv=1 snap=0", id, res_valid, snap);
    else n_pass++;
  endtask

  task automatic test_contention(input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic w;
    req0 = 1'b1; x0 = a0; y0 = b0;
    req1 = 1'b1; x1 = a1; y1 = b1;
    w = pick(1'b1, 1'b1, model_last);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{id: w, data: (w ? (a1 & b1) : (a0 & b0))});
      model_last = w;
      @(negedge clk);
      n_total++;
      if (snap !== exp_grant(w, w ? a1 : a0, w ? b1 : b0))
        $display("FAIL contention_grant k=%0d got %h want %h", k, snap, exp_grant(w, w ? a1 : a0, w ? b1 : b0));
      else n_pass++;
      if (w) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      n_total++;
      if ({res_valid, busy, gnt0, gnt1} !== 4'b1000)
        $display("FAIL contention_eval k=%0d got %b want 1000", k, {res_valid, busy, gnt0, gnt1});
      else n_pass++;
      w = ~w;
    end
  endtask

  // req0 held continuously: round-robin must still serve requester 1.
  task automatic test_hold();
    logic w;
    int   n = 0;
    req0 = 1'b1; x0 = 4'h7; y0 = 4'hD;
    req1 = 1'b1; x1 = 4'hE; y1 = 4'hB;
    while ((req0 || req1) && n < 6) begin
      w = pick(req0, req1, model_last);
      model_last = w;
      sb.push_back('{id: w, data: (w ? (x1 & y1) : (x0 & y0))});
      @(negedge clk);
      n_total++;
      if ({gnt0, gnt1} !== {~w, w})
        $display("FAIL hold_grant n=%0d got %b want %b", n, {gnt0, gnt1}, {~w, w});
      else n_pass++;
      if (w) req1 = 1'b0;
      n++;
      if (n == 3) req0 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_late();
    req0 = 1'b1; x0 = 4'h9; y0 = 4'hC;
    sb.push_back('{id: 1'b0, data: 4'h9 & 4'hC});
    model_last = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; x1 = 4'h5; y1 = 4'h7;
    sb.push_back('{id: 1'b1, data: 4'h5 & 4'h7});
    @(negedge clk);
    n_total++;
    if ({res_valid, gnt1, busy} !== 3'b100)
      $display("FAIL late_not_early got rv,gnt1,busy=%b want 100", {res_valid, gnt1, busy});
    else n_pass++;
    model_last = 1'b1;
    @(negedge clk);
    n_total++;
    if (snap !== exp_grant(1'b1, 4'h5, 4'h7))
      $display("FAIL late_grant got %h want %h", snap, exp_grant(1'b1, 4'h5, 4'h7));
    else n_pass++;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid(input logic id);
    if (id == 1'b0) begin req0 = 1'b1; x0 = 4'hF; y0 = 4'hF; end
    else begin req1 = 1'b1; x1 = 4'hF; y1 = 4'hF; end
    @(negedge clk);
    n_total++;
    if (snap !== exp_grant(id, 4'hF, 4'hF))
      $display("FAIL midrst_grant id=%0d got %h want %h", id, snap, exp_grant(id, 4'hF, 4'hF));
    else n_pass++;
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    n_total++;
    if ({snap, res_valid, res_id, res_data} !== '0)
      $display("FAIL midrst_outputs id=%0d got snap=%h rv=%b id=%b data=%h want all 0",
               id, snap, res_valid, res_id, res_data);
    else n_pass++;
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 4'h1, 4'h1);
    test_single(1'b1, 4'h1, 4'h0);
    test_single(1'b0, 4'hA, 4'h6);
    test_single(1'b1, 4'hF, 4'h3);
    test_contention(4'h3, 4'h5, 4'hC, 4'hA);
    test_contention(4'hF, 4'h8, 4'h6, 4'h6);
    test_hold();
    test_late();
    test_reset_mid(1'b1);
    test_reset_mid(1'b0);
    // A grant to requester 0 was aborted above; reset must have restored last=1.
    test_contention(4'h2, 4'h3, 4'h9, 4'h9);
    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL outstanding_results got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
